tanh_grad: RTL and testbench
============================

TANH_GRAD -- requirements
Module: tanh_grad

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in signed Q8.8 fixed point; only 16 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning y_in/grad_in hold a valid pair.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts the pair this cycle.
REQ-006 SHALL have port y_in, input, 16, forward tanh output, signed Q8.8.
REQ-007 SHALL have port grad_in, input, 16, upstream gradient dL/dy, signed Q8.8.
REQ-008 SHALL have port out_valid, output, 1, meaning grad_out is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts grad_out this cycle.
REQ-010 SHALL have port grad_out, output, 16, dL/dx = grad_in*(1-y^2), signed Q8.8.
REQ-011 SHALL have port busy, output, 1, high when any pipeline stage holds valid data.

Function
REQ-012 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready, both in the same clock edge.
REQ-013 SHALL implement a 3-stage elastic pipeline (S1 square, S2 complement, S3 multiply), each stage with its own valid bit.
REQ-014 SHALL load a stage when it is empty or its contents move on in the same cycle; otherwise it holds.
REQ-015 SHALL drive in_ready = !S1_valid || S1 advancing, combinationally from out_ready through the stall chain.
REQ-016 SHALL give latency 3 cycles from input transfer to out_valid with out_ready held high, throughput 1 pair/cycle.
REQ-017 S1 SHALL clamp y to [0xFF00,0x0100] (magnitude > 1.0 treated as exactly +/-1.0), compute sq = (y*y)[23:8] (Q8.8, range 0x0000..0x0100) and register grad_in alongside.
REQ-018 S2 SHALL compute d = 0x0100 - sq as a 9-bit unsigned value (range 0..0x100).
REQ-019 S3 SHALL compute prod = signed grad * unsigned d (25-bit), then grad_out = prod >>> 8 (arithmetic shift, low 16 bits); |grad_out| <= |grad_in| so no overflow occurs.
REQ-020 SHALL hold grad_out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve order and never drop or duplicate a pair under any in_valid/out_ready pattern.
REQ-022 With all stages full and out_ready low, in_ready SHALL be 0; a simultaneous out transfer and in transfer in a full pipe SHALL both complete.
REQ-023 busy SHALL equal S1_valid|S2_valid|S3_valid.

Reset
REQ-024 Assertion of rst_n low SHALL immediately clear all valid bits and data registers to 0, giving out_valid=0, grad_out=0x0000, busy=0, in_ready=1.
REQ-025 Reset mid-stream SHALL discard all in-flight pairs; no result for them appears after release.
REQ-026 First transfer after release SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 Macro TANH_GRAD_ROUND_EN defined: S3 SHALL compute grad_out = (prod + 0x80) >>> 8 (round half up); result still cannot overflow.
REQ-028 Macro TANH_GRAD_ROUND_EN undefined: S3 SHALL truncate (floor) as in REQ-019; latency and handshake identical in both builds.

Verification
REQ-029 y=0x0000, g=0x0100, out_ready=1 -> grad_out=0x0100 with out_valid exactly 3 cycles after input transfer.
REQ-030 y=0x0080, g=0x0100 -> 0x00C0; y=0xFF80, g=0xFF00 -> 0xFF40; y=0x0180, g=0x7FFF -> 0x0000 (clamp).
REQ-031 y=0x0010, g=0x0003 -> 0x0002 without TANH_GRAD_ROUND_EN, 0x0003 with it.
REQ-032 out_ready=0 for 6 cycles while 5 pairs offered back-to-back -> exactly 3 accepted, in_ready low, first result held stable; release -> all 5 results in order, no loss.
REQ-033 Random in_valid/out_ready (50% each), 10000 pairs -> output stream matches reference model bit-exactly and in order.
REQ-034 rst_n pulsed low with 3 pairs in flight -> out_valid=0 immediately, busy=0, none of the 3 results ever emitted.

Source files
------------

// File: rtl/tanh_grad.sv
// tanh_grad: backward pass of tanh, grad_out = grad_in * (1 - y^2), in signed Q8.8.
// It is a 3-stage elastic pipeline: S1 squares, S2 complements, S3 multiplies.
// Each stage has its own valid bit. A stage loads when it is empty or when its
// contents move on in the same cycle, so stalls ripple back combinationally.
//
// Ports:
//   clk       - clock; all state updates on its rising edge
//   rst_n     - asynchronous active-low reset; clears all valid and data registers
//   in_valid  - y_in / grad_in hold a valid pair
//   in_ready  - the pair is accepted this cycle
//   y_in      - forward tanh output, signed Q8.8
//   grad_in   - upstream gradient dL/dy, signed Q8.8
//   out_valid - grad_out is valid
//   out_ready - downstream accepts grad_out this cycle
//   grad_out  - dL/dx, signed Q8.8
//   busy      - at least one pipeline stage holds valid data
//
// Build option: define TANH_GRAD_ROUND_EN to round S3 half up. Without it, S3
// truncates (floor). Latency and handshake are the same in both builds.
// Only DATA_W = 16 is supported.

module tanh_grad #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] grad_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grad_out,
  output logic              busy
);

  logic               r_s1_v, r_s2_v, r_s3_v;
  logic [8:0]         r_s1_sq;
  logic [15:0]        r_s1_grad;
  logic [8:0]         r_s2_d;
  logic [15:0]        r_s2_grad;
  logic [15:0]        r_s3_out;

  logic               w_s1_en, w_s2_en, w_s3_en;
  logic signed [9:0]  w_yc;
  logic signed [19:0] w_yc_ext;
  logic signed [19:0] w_sq_full;
  logic [8:0]         w_d;
  logic signed [24:0] w_g_ext;
  logic signed [24:0] w_d_ext;
  logic signed [24:0] w_prod;
  logic signed [24:0] w_prod_sel;
  logic               w_unused_bits;

  // Stall chain: a stage may load when it is empty or its occupant leaves this cycle.
  assign w_s3_en  = !r_s3_v || out_ready;
  assign w_s2_en  = !r_s2_v || w_s3_en;
  assign w_s1_en  = !r_s1_v || w_s2_en;
  assign in_ready = w_s1_en;

  // Clamp y to [-1.0, +1.0]. The clamped value fits in 10 signed bits.
  always_comb begin
    w_yc = y_in[9:0];
    if ($signed(y_in) > 16'sh0100) begin
      w_yc = 10'sh100;
    end else if ($signed(y_in) < -16'sh0100) begin
      w_yc = -10'sh100;
    end
  end

  assign w_yc_ext  = {{10{w_yc[9]}}, w_yc};
  assign w_sq_full = w_yc_ext * w_yc_ext;  // max 0x10000, so bits [16:8] hold sq

  assign w_d = 9'h100 - r_s1_sq;

  assign w_g_ext = {{9{r_s2_grad[15]}}, r_s2_grad};
  assign w_d_ext = {16'd0, r_s2_d};
  assign w_prod  = w_g_ext * w_d_ext;

`ifdef TANH_GRAD_ROUND_EN
  assign w_prod_sel = w_prod + 25'sd128;
`else
  assign w_prod_sel = w_prod;
`endif

  assign w_unused_bits = ^{w_sq_full[19:17], w_sq_full[7:0], w_prod_sel[24], w_prod_sel[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_sq   <= '0;
      r_s1_grad <= '0;
      r_s2_d    <= '0;
      r_s2_grad <= '0;
      r_s3_out  <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1_sq   <= w_sq_full[16:8];
          r_s1_grad <= grad_in[15:0];
        end
      end
      if (w_s2_en) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_d    <= w_d;
          r_s2_grad <= r_s1_grad;
        end
      end
      if (w_s3_en) begin
        r_s3_v <= r_s2_v;
        if (r_s2_v) begin
          // |d| <= 1.0, so the shifted product always fits in 16 bits.
          r_s3_out <= w_prod_sel[23:8];
        end
      end
    end
  end

  assign out_valid = r_s3_v;
  assign grad_out  = r_s3_out;
  assign busy      = r_s1_v | r_s2_v | r_s3_v;

endmodule

// File: tb/tb_tanh_grad.sv
module tb_tanh_grad;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y_in;
  logic [15:0] grad_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] grad_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [15:0] q_exp[$];

  tanh_grad #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .grad_in   (grad_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the definition of the gradient.
  function automatic logic [15:0] ref_grad(input logic [15:0] y, input logic [15:0] g);
    int yi, gi, sq, d, p;
    yi = int'($signed(y));
    if (yi > 256) yi = 256;
    if (yi < -256) yi = -256;
    sq = (yi * yi) / 256;
    d  = 256 - sq;
    gi = int'($signed(g));
    p  = gi * d;
`ifdef TANH_GRAD_ROUND_EN
    p = p + 128;
`endif
    p = p >>> 8;
    return p[15:0];
  endfunction

  // Scoreboard consumer: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [15:0] exp_v;
      n_vec++;
      n_out++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got=%h required=none", grad_out);
      end else begin
        exp_v = q_exp.pop_front();
        if (grad_out !== exp_v) begin
          n_err++;
          $display("FAIL grad_out got=%h required=%h", grad_out, exp_v);
        end
      end
    end
  end

  // Offer one pair until accepted; push its expected result at acceptance.
  task automatic drive_pair(input logic [15:0] y, input logic [15:0] g,
                            input logic [15:0] exp_v);
    y_in     = y;
    grad_in  = g;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q_exp.push_back(exp_v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout got=in_ready_low required=accept");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (q_exp.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (q_exp.size() != 0 || busy) begin
      n_err++;
      $display("FAIL drain got=%0d_pending required=0", q_exp.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = '0;
    grad_in   = '0;
    #3;
    n_vec += 4;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (grad_out !== 16'h0000) begin n_err++; $display("FAIL rst_grad_out got=%h required=0000", grad_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int edges;
    out_ready = 1'b1;
    drive_pair(16'h0000, 16'h0100, 16'h0100);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    n_vec++;
    if (edges !== 3) begin
      n_err++;
      $display("FAIL latency got=%0d required=3", edges);
    end
    wait_drain();
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    drive_pair(16'h0080, 16'h0100, 16'h00C0);
    drive_pair(16'hFF80, 16'hFF00, 16'hFF40);
    drive_pair(16'h0180, 16'h7FFF, 16'h0000);
`ifdef TANH_GRAD_ROUND_EN
    drive_pair(16'h0010, 16'h0003, 16'h0003);
`else
    drive_pair(16'h0010, 16'h0003, 16'h0002);
`endif
    drive_pair(16'hFE00, 16'h1234, 16'h0000);
    drive_pair(16'h0000, 16'h8000, 16'h8000);
    wait_drain();
  endtask

  task automatic test_back_to_back_stall();
    int acc = 0;
    int out0;
    logic have_held = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] ys[5] = '{16'h0010, 16'h0040, 16'hFFC0, 16'h00F0, 16'h0100};
    logic [15:0] gs[5] = '{16'h0100, 16'hFE80, 16'h0333, 16'h7FFF, 16'h0055};
    out0 = n_out;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      y_in     = ys[acc];
      grad_in  = gs[acc];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        q_exp.push_back(ref_grad(ys[acc], gs[acc]));
        acc++;
      end
      if (out_valid) begin
        if (!have_held) begin
          have_held = 1'b1;
          held = grad_out;
        end else begin
          n_vec++;
          if (grad_out !== held) begin
            n_err++;
            $display("FAIL stall_hold got=%h required=%h", grad_out, held);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec += 3;
    if (acc !== 3) begin n_err++; $display("FAIL stall_accepted got=%0d required=3", acc); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid got=%b required=1", out_valid); end
    out_ready = 1'b1;
    for (int i = 3; i < 5; i++) drive_pair(ys[i], gs[i], ref_grad(ys[i], gs[i]));
    wait_drain();
    n_vec++;
    if (n_out - out0 !== 5) begin
      n_err++;
      $display("FAIL stall_out_count got=%0d required=5", n_out - out0);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int tmp;
    logic acc;
    logic done = 1'b0;
    for (int cyc = 0; cyc < 80000; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 10000 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0) begin
          tmp = int'($urandom);
        end else begin
          tmp = int'($urandom_range(0, 640)) - 320;
        end
        y_in     = tmp[15:0];
        tmp      = int'($urandom);
        grad_in  = tmp[15:0];
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = 1'b0;
      if (in_valid && in_ready) begin
        q_exp.push_back(ref_grad(y_in, grad_in));
        sent++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
      if (sent == 10000 && q_exp.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL random_timeout got=%0d_sent_%0d_pending required=10000_sent_0_pending",
               sent, q_exp.size());
    end
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    int out0;
    out_ready = 1'b0;
    drive_pair(16'h0020, 16'h0100, 16'h0000);
    drive_pair(16'h0030, 16'h0200, 16'h0000);
    drive_pair(16'h0040, 16'h0300, 16'h0000);
    rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got=%b required=0", out_valid); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b required=0", busy); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got=%b required=1", in_ready); end
    if (grad_out !== 16'h0000) begin n_err++; $display("FAIL mid_rst_grad_out got=%h required=0000", grad_out); end
    q_exp.delete();
    out0 = n_out;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    y_in      = 16'h0080;
    grad_in   = 16'h0100;
    in_valid  = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_accept got=%b required=1", in_ready);
    end else begin
      q_exp.push_back(16'h00C0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    wait_drain();
    n_vec++;
    if (n_out - out0 !== 1) begin
      n_err++;
      $display("FAIL mid_rst_out_count got=%0d required=1", n_out - out0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back_stall();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
